// File: rtl/thread_scheduler_pkg.sv
// Shared encodings and widths for the two-thread fetch scheduler.
// Optional perf counters are enabled with SCHED_PERF_CNT_EN.
package thread_scheduler_pkg;

  localparam logic [1:0] THREAD_RUN     = 2'b00;
  localparam logic [1:0] THREAD_BLOCKED = 2'b01;
  localparam logic [1:0] THREAD_HALTED  = 2'b10;

  localparam int CNT_W = 8;
  localparam int TID_W = 1;

  localparam int PERF_W = 16;

endpackage

// File: rtl/thread_scheduler_fsm.sv
// One thread's RUN/BLOCKED/HALTED state, block timeout counter
// and forced-release pulse.
module thread_state_fsm
  import thread_scheduler_pkg::*;
#(
  parameter int BLOCK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       block,
  input  logic       resolve,
  input  logic       halt,
  output logic [1:0] state,
  output logic [1:0] state_nxt,
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] TO_LIM =
    CNT_W'(BLOCK_TIMEOUT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             to_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    to_nxt    = 1'b0;
    if (halt) begin
      state_nxt = THREAD_HALTED;
      cnt_nxt   = '0;
    end else begin
      case (state)
        THREAD_RUN: begin
          if (block) begin
            state_nxt = THREAD_BLOCKED;
            cnt_nxt   = '0;
          end
        end
        THREAD_BLOCKED: begin
          if (block) begin
            cnt_nxt = '0;
          end else if (resolve) begin
            state_nxt = THREAD_RUN;
            cnt_nxt   = '0;
          end else if (cnt == TO_LIM) begin
            state_nxt = THREAD_RUN;
            cnt_nxt   = '0;
            to_nxt    = 1'b1;
          end else if (cnt != '1) begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        // HALTED and the unused 2'b11 code are sticky
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= THREAD_RUN;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      timeout_err <= to_nxt;
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Round-robin fetch-thread selector for the two-thread core.
// Define SCHED_PERF_CNT_EN to add fetch/idle perf counters.
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int BLOCK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_is_branch,
  input  logic             br_resolve_valid,
  input  logic             br_resolve_tid,
  input  logic             halt_valid,
  input  logic             halt_tid,
`ifdef SCHED_PERF_CNT_EN
  output logic [PERF_W-1:0] fetch_cnt0,
  output logic [PERF_W-1:0] fetch_cnt1,
  output logic [PERF_W-1:0] idle_cnt,
`endif
  output logic             fetch_valid,
  output logic [TID_W-1:0] fetch_thread_id,
  output logic [3:0]       thread_state,
  output logic             all_halted,
  output logic             timeout_err
);

  logic [1:0] st0, st1, nx0, nx1;
  logic       to0, to1;
  logic       blk0, blk1;
  logic       rsv0, rsv1;
  logic       hlt0, hlt1;
  logic [TID_W-1:0] last_tid;
  logic [TID_W-1:0] pref;
  logic [TID_W-1:0] pick_tid;
  logic       pick_v;
  logic       run0, run1;
  logic       pref_run, last_run;

  assign blk0 = fetch_valid & fetch_is_branch
              & ~fetch_thread_id[0];
  assign blk1 = fetch_valid & fetch_is_branch
              & fetch_thread_id[0];
  assign rsv0 = br_resolve_valid & ~br_resolve_tid;
  assign rsv1 = br_resolve_valid & br_resolve_tid;
  assign hlt0 = halt_valid & ~halt_tid;
  assign hlt1 = halt_valid & halt_tid;

  thread_state_fsm #(
    .BLOCK_TIMEOUT(BLOCK_TIMEOUT)
  ) u_fsm0 (
    .clk        (clk),
    .rst        (rst),
    .block      (blk0),
    .resolve    (rsv0),
    .halt       (hlt0),
    .state      (st0),
    .state_nxt  (nx0),
    .timeout_err(to0)
  );

  thread_state_fsm #(
    .BLOCK_TIMEOUT(BLOCK_TIMEOUT)
  ) u_fsm1 (
    .clk        (clk),
    .rst        (rst),
    .block      (blk1),
    .resolve    (rsv1),
    .halt       (hlt1),
    .state      (st1),
    .state_nxt  (nx1),
    .timeout_err(to1)
  );

  // select on post-edge states so a new block/halt is honoured at once
  assign run0     = (nx0 == THREAD_RUN);
  assign run1     = (nx1 == THREAD_RUN);
  assign pref     = ~last_tid;
  assign pref_run = pref[0] ? run1 : run0;
  assign last_run = last_tid[0] ? run1 : run0;

  always_comb begin
    pick_v   = 1'b0;
    pick_tid = last_tid;
    unique case (1'b1)
      pref_run: begin
        pick_v   = 1'b1;
        pick_tid = pref;
      end
      (~pref_run & last_run): begin
        pick_v   = 1'b1;
        pick_tid = last_tid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid     <= 1'b0;
      fetch_thread_id <= '0;
      last_tid        <= '1;
      all_halted      <= 1'b0;
    end else begin
      fetch_valid <= pick_v;
      all_halted  <= nx0[1] & nx1[1];
      if (pick_v) begin
        fetch_thread_id <= pick_tid;
        last_tid        <= pick_tid;
      end
    end
  end

  assign thread_state = {st1, st0};
  assign timeout_err  = to0 | to1;

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt0 <= '0;
      fetch_cnt1 <= '0;
      idle_cnt   <= '0;
    end else if (!fetch_valid) begin
      if (idle_cnt != '1)
        idle_cnt <= idle_cnt + 1'b1;
    end else if (fetch_thread_id[0]) begin
      if (fetch_cnt1 != '1)
        fetch_cnt1 <= fetch_cnt1 + 1'b1;
    end else begin
      if (fetch_cnt0 != '1)
        fetch_cnt0 <= fetch_cnt0 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed vector bench for thread_scheduler with BLOCK_TIMEOUT=3.
// Each record drives one cycle and lists the outputs after the edge.
module tb_thread_scheduler;

  typedef struct {
    logic       rst;
    logic       br;
    logic       rv;
    logic       rtid;
    logic       hv;
    logic       htid;
    logic       fv;
    logic       tid;
    logic [3:0] st;
    logic       ah;
    logic       te;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetch_is_branch = 1'b0;
  logic       br_resolve_valid = 1'b0;
  logic       br_resolve_tid = 1'b0;
  logic       halt_valid = 1'b0;
  logic       halt_tid = 1'b0;
  logic       fetch_valid;
  logic [0:0] fetch_thread_id;
  logic [3:0] thread_state;
  logic       all_halted;
  logic       timeout_err;

  int total = 0;
  int bad = 0;
  int n = 0;
  vec_t v[40];

  thread_scheduler #(
    .BLOCK_TIMEOUT(3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_is_branch (fetch_is_branch),
    .br_resolve_valid(br_resolve_valid),
    .br_resolve_tid  (br_resolve_tid),
    .halt_valid      (halt_valid),
    .halt_tid        (halt_tid),
    .fetch_valid     (fetch_valid),
    .fetch_thread_id (fetch_thread_id),
    .thread_state    (thread_state),
    .all_halted      (all_halted),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic add(
    input logic r, b, rv_, rt, hv_, ht,
    input logic fv, tid, input logic [3:0] st,
    input logic ah, te
  );
    v[n] = '{r, b, rv_, rt, hv_, ht, fv, tid, st, ah, te};
    n++;
  endtask

  task automatic chk(
    input string nm, input int idx,
    input logic [3:0] act, input logic [3:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h",
               nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t e);
    chk("fetch_valid", idx, {3'b0, fetch_valid}, {3'b0, e.fv});
    chk("fetch_tid", idx, {3'b0, fetch_thread_id}, {3'b0, e.tid});
    chk("thread_state", idx, thread_state, e.st);
    chk("all_halted", idx, {3'b0, all_halted}, {3'b0, e.ah});
    chk("timeout_err", idx, {3'b0, timeout_err}, {3'b0, e.te});
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst              = v[i].rst;
      fetch_is_branch  = v[i].br;
      br_resolve_valid = v[i].rv;
      br_resolve_tid   = v[i].rtid;
      halt_valid       = v[i].hv;
      halt_tid         = v[i].htid;
      @(posedge clk);
      #1;
      chk_all(i, v[i]);
    end
  endtask

  vec_t rv_exp;
  int   split;

  initial begin
    // alternation after reset
    add(0,0,0,0,0,0, 1,0,4'b0000,0,0);
    add(0,0,0,0,0,0, 1,1,4'b0000,0,0);
    add(0,0,0,0,0,0, 1,0,4'b0000,0,0);
    // thread 0 branch, resolved three cycles later
    add(0,1,0,0,0,0, 1,1,4'b0001,0,0);
    add(0,0,0,0,0,0, 1,1,4'b0001,0,0);
    add(0,0,0,0,0,0, 1,1,4'b0001,0,0);
    add(0,0,1,0,0,0, 1,0,4'b0000,0,0);
    add(0,0,0,0,0,0, 1,1,4'b0000,0,0);
    // both threads block, released by timeout
    add(0,1,0,0,0,0, 1,0,4'b0100,0,0);
    add(0,1,0,0,0,0, 0,0,4'b0101,0,0);
    add(0,0,0,0,0,0, 0,0,4'b0101,0,0);
    add(0,0,0,0,0,0, 0,0,4'b0101,0,0);
    add(0,0,0,0,0,0, 1,1,4'b0001,0,1);
    add(0,0,0,0,0,0, 1,0,4'b0000,0,1);
    add(0,0,0,0,0,0, 1,1,4'b0000,0,0);
    // resolve and new branch on thread 1 together
    add(0,1,1,1,0,0, 1,0,4'b0100,0,0);
    add(0,0,0,0,0,0, 1,0,4'b0100,0,0);
    add(0,0,0,0,0,0, 1,0,4'b0100,0,0);
    add(0,0,0,0,0,0, 1,0,4'b0100,0,0);
    add(0,0,0,0,0,0, 1,1,4'b0000,0,1);
    // halt thread 1, then thread 0
    add(0,0,0,0,1,1, 1,0,4'b1000,0,0);
    add(0,0,0,0,0,0, 1,0,4'b1000,0,0);
    add(0,0,0,0,0,0, 1,0,4'b1000,0,0);
    add(0,0,0,0,1,0, 0,0,4'b1010,1,0);
    add(0,0,0,0,0,0, 0,0,4'b1010,1,0);
    // reset, then thread 0 blocked and thread 1 halted
    add(1,0,0,0,0,0, 0,0,4'b0000,0,0);
    add(0,0,0,0,0,0, 1,0,4'b0000,0,0);
    add(0,1,0,0,0,0, 1,1,4'b0001,0,0);
    add(0,0,0,0,1,1, 0,1,4'b1001,0,0);
    split = n;
    // after the asynchronous reset
    add(1,0,0,0,0,0, 0,0,4'b0000,0,0);
    add(0,0,0,0,0,0, 1,0,4'b0000,0,0);
    add(0,0,0,0,0,0, 1,1,4'b0000,0,0);
    add(0,0,0,0,0,0, 1,0,4'b0000,0,0);

    rv_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, rv_exp);

    run(0, split - 1);

    // mid-cycle reset must clear outputs without a clock edge
    #2;
    rst = 1'b1;
    #1;
    chk_all(-2, rv_exp);

    run(split, n - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thread_scheduler.md
# thread_scheduler

Per-cycle fetch-thread selector for the two-thread fine-grained interleaved core. Sits in front of the per-thread PC table and drives the fetch thread ID and fetch-valid qualifier every cycle. Tracks a per-thread state (RUN / BLOCKED / HALTED) so that a thread with an unresolved branch or an executed HALT is skipped. Alternates between eligible threads round-robin.

## Interface
Parameters:
- BLOCK_TIMEOUT, 15: max cycles a thread may stay BLOCKED before forced release (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_is_branch  in  1  predecode: instruction fetched this cycle (thread fetch_thread_id, fetch_valid=1) is a branch.
- br_resolve_valid  in  1  branch resolved in EX/WB this cycle.
- br_resolve_tid  in  1  thread of resolved branch.
- halt_valid  in  1  HALT retired this cycle.
- halt_tid  in  1  thread of retired HALT.
- fetch_valid  out  1  registered; 1 = fetch slot used this cycle. Downstream PC update must be qualified by it.
- fetch_thread_id  out  1  registered; thread owning this cycle's fetch slot.
- thread_state  out  4  registered; {state[1], state[0]}, 2 bits each.
- all_halted  out  1  registered; both threads HALTED.
- timeout_err  out  1  registered one-cycle pulse on forced BLOCKED release.

## Operation
- Per-thread states: RUN=2'b00, BLOCKED=2'b01, HALTED=2'b10; 2'b11 unused, treated as HALTED.
- RUN -> BLOCKED: fetch_valid & fetch_is_branch for that thread; timeout counter loads 0.
- BLOCKED -> RUN: br_resolve_valid & br_resolve_tid match, or counter reaches BLOCK_TIMEOUT (then timeout_err=1 next cycle).
- Any -> HALTED: halt_valid & halt_tid match. HALTED exits only via rst.
- Priority per thread, same cycle: halt > new branch block > resolve/timeout > hold. Resolve and new branch on same thread in same cycle: thread stays BLOCKED, counter reloads 0.
- Counter: 8-bit, increments while BLOCKED, saturates, cleared on leaving BLOCKED.
- Selection uses next-cycle states (after this edge's transitions). Register last_tid. Prefer ~last_tid if it is RUN, else last_tid if RUN, else fetch_valid=0 and last_tid holds. On valid pick, fetch_thread_id and last_tid take the picked thread.
- When fetch_valid=0, fetch_thread_id holds its previous value.

## Timing
- Reset values: fetch_valid=0, fetch_thread_id=0, last_tid=1, both states RUN, thread_state=4'b0000, all_halted=0, timeout_err=0, counters 0.
- First edge after rst deasserts: fetch_valid=1, fetch_thread_id=0. Next edge: thread 1. Then strict alternation while both are RUN.
- Branch fetched in cycle n: that thread is not selected in cycle n+1. Resolve in cycle m: eligible in cycle m+1.
- Halt in cycle n: state=HALTED and excluded from cycle n+1. all_halted rises in the same cycle as the second halt's state change.
- Reset mid-operation: all registers return to reset values asynchronously. Any pending block or halt is discarded.

## Configuration
- SCHED_PERF_CNT_EN defined: adds outputs fetch_cnt0 / fetch_cnt1 (16-bit, saturating at 16'hFFFF) and idle_cnt (16-bit, saturating). These count valid fetches per thread and cycles with fetch_valid=0. All reset to 0.
- Undefined: counters and their ports are absent. Behaviour is otherwise identical.

## Structure
- Shared defines file holds the state encodings (THREAD_RUN, THREAD_BLOCKED, THREAD_HALTED), the timeout counter width, and the thread ID width.
- Sub-module thread_state_fsm, instantiated twice. It holds one thread's state, timeout counter and timeout pulse, and takes decoded block / resolve / halt strobes. The top level holds the round-robin select, output registers and optional counters.

## Test plan
- Reset release, no events, 6 cycles -> fetch_thread_id 0,1,0,1,0,1, fetch_valid=1 throughout.
- Thread 0 fetches branch in cycle 2, resolve in cycle 5 -> cycles 3-5 thread 1 only; cycle 6 thread 0 again. thread_state[1:0]=01 during cycles 3-5.
- Both threads blocked, no resolve, BLOCK_TIMEOUT=3 -> fetch_valid=0 for the idle window, timeout_err pulses once per thread, then fetch resumes.
- Same-cycle resolve and new branch on thread 1 -> thread 1 remains BLOCKED, counter restarts at 0.
- Halt thread 1, then halt thread 0 -> only thread 0 fetches after the first halt. After the second halt: fetch_valid=0, all_halted=1, fetch_thread_id held.
- Assert rst while thread 0 is BLOCKED and thread 1 is HALTED -> all outputs return to reset values immediately. After release, alternation restarts at thread 0.
